seq_pattern_generator: RTL and testbench
========================================

Name: seq_pattern_generator

Overview:
- Serial stimulus source, the transmit-side counterpart of the team's Moore sequence detectors.
- Shifts a programmable WIDTH-bit pattern out on a 1-bit serial line, MSB first.
- Supports a repeat count and an idle-gap length between frames, so a detector's non-overlapping and overlapping behaviour can be driven from RTL instead of hand-written stimulus.
- Sits upstream of the detector; its `x` output feeds the detector's `x` input directly.

Parameters:
- WIDTH, 4: pattern length in bits (≥2).
- REPEAT_W, 4: width of the repeat-count input.
- GAP_W, 4: width of the inter-frame gap input.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a burst; sampled only in IDLE.
- pattern  input  WIDTH  bit pattern to transmit; captured on accepted start.
- repeat_cnt  input  REPEAT_W  extra frames; burst = repeat_cnt+1 frames; captured on start.
- gap  input  GAP_W  idle cycles between frames (0 = back-to-back); captured on start.
- x  output  1  serial data bit.
- valid  output  1  x carries a pattern bit this cycle.
- frame  output  1  high on the first bit of each frame.
- busy  output  1  burst in progress (SHIFT, GAP or DONE).
- done  output  1  one-cycle pulse after the last bit of the burst.

Behaviour:
- Reset (async, any state): state=IDLE; x=0, valid=0, frame=0, busy=0, done=0; shift register, bit counter, frame counter and gap counter cleared. Outputs reach these values immediately, without waiting for a clock edge.
- Moore FSM. All outputs decode from registered state and registers only; there is no combinational path from inputs to outputs.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - If start=1 at a rising edge: load shreg←pattern, frames_left←repeat_cnt, gap_reg←gap, bitcnt←0; go to SHIFT.
  - The first bit is visible in the cycle immediately after that edge.
- SHIFT:
  - x=shreg[WIDTH-1], valid=1, busy=1; frame=1 when bitcnt==0.
  - Each edge: shift left, bitcnt++.
  - On the edge where bitcnt==WIDTH-1:
    - if frames_left==0 → DONE;
    - else if gap_reg==0 → reload shreg from the captured pattern, frames_left--, bitcnt←0, stay in SHIFT (no dead cycle);
    - else → GAP with gapcnt←gap_reg.
- GAP:
  - x=0, valid=0, frame=0, busy=1.
  - gapcnt decrements each edge. On the edge where gapcnt==1: reload shreg, frames_left--, bitcnt←0, go to SHIFT.
  - The gap therefore lasts exactly gap_reg cycles.
- DONE:
  - done=1, busy=1, x=0, valid=0 for exactly one cycle, then IDLE.
- start handling:
  - Ignored in SHIFT, GAP and DONE. No queuing.
  - A start pulse held through DONE is accepted on the first edge in IDLE.
- Captured copies: pattern/repeat_cnt/gap changes during a burst have no effect.
- Maximum-size values:
  - repeat_cnt all-ones → 2^REPEAT_W frames.
  - gap all-ones → 2^GAP_W−1 idle cycles.
  - No wrap or overflow in either case.
- Total burst length in cycles: (repeat_cnt+1)*WIDTH + repeat_cnt*gap + 1 (DONE).
- Reset mid-burst: the burst is abandoned and there is no done pulse. After reset release, the first start is accepted normally.

Optional Feature:
- Macro: SEQ_GEN_LSB_FIRST_EN.
- Defined: serialisation is LSB first. x=shreg[0], shift right; pattern 1011 is sent as 1,1,0,1.
- Not defined: MSB first as above.
- FSM, timing, frame/done behaviour and port list are identical in both builds.

Test Plan:
1. Reset, then pattern=4'b1011, repeat_cnt=0, gap=0, start for 1 cycle → x=1,0,1,1 on 4 consecutive cycles with valid=1, frame=1 only on the first; done=1 on cycle 5; busy high for 5 cycles; back to IDLE.
2. pattern=4'b1001, repeat_cnt=1, gap=2 → x/valid sequence 1,0,0,1 (valid) then 0,0 (valid=0) then 1,0,0,1 (valid); frame pulses on cycles 1 and 7; done on cycle 11.
3. pattern=4'b1010, repeat_cnt=2, gap=0 → 12 consecutive valid cycles of 101010101010; frame on cycles 1, 5, 9; done on cycle 13.
4. Start a 1011 burst, change pattern to 0000 and pulse start again on its 2nd bit → output unchanged (1011), single done, the second start is ignored.
5. Assert rst asynchronously mid-clock during the 3rd bit of a burst → x, valid, busy, done are 0 before the next edge, no done pulse; after release, start with 1100 → 1,1,0,0 emitted normally.
6. Build with SEQ_GEN_LSB_FIRST_EN defined, pattern=4'b1011, repeat 0 → x=1,1,0,1; frame and done timing identical to scenario 1.

Source files
------------

// File: rtl/seq_pattern_generator.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pattern_generator
//  Description : Serial stimulus source for the Moore sequence detectors.
//                Shifts a WIDTH-bit pattern out on x (MSB first by default)
//                for repeat_cnt+1 frames with gap idle cycles between frames.
//                A one-cycle done pulse follows the last bit of the burst.
//  Ports       : clk        - system clock, rising edge
//                rst        - asynchronous active-high reset
//                start      - begin a burst (sampled only in IDLE)
//                pattern    - bit pattern, captured on accepted start
//                repeat_cnt - extra frames (burst = repeat_cnt+1 frames)
//                gap        - idle cycles between frames (0 = back-to-back)
//                x          - serial data bit
//                valid      - x carries a pattern bit this cycle
//                frame      - first bit of each frame
//                busy       - burst in progress (SHIFT, GAP or DONE)
//                done       - one-cycle pulse after the last bit
//  Options     : `define SEQ_GEN_LSB_FIRST_EN to serialise LSB first.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_generator #(
    parameter int WIDTH    = 4,
    parameter int REPEAT_W = 4,
    parameter int GAP_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    pattern,
    input  logic [REPEAT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0]    gap,
    output logic                x,
    output logic                valid,
    output logic                frame,
    output logic                busy,
    output logic                done
);

    localparam int c_BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_BCW-1:0] c_LAST = c_BCW'(WIDTH - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SHIFT = 2'd1;
    localparam logic [1:0] c_S_GAP   = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    logic [1:0]          r_state,       w_state_nxt;
    logic [WIDTH-1:0]    r_shreg,       w_shreg_nxt;
    logic [WIDTH-1:0]    r_pat,         w_pat_nxt;
    logic [REPEAT_W-1:0] r_frames_left, w_frames_left_nxt;
    logic [GAP_W-1:0]    r_gap,         w_gap_nxt;
    logic [GAP_W-1:0]    r_gapcnt,      w_gapcnt_nxt;
    logic [c_BCW-1:0]    r_bitcnt,      w_bitcnt_nxt;
    logic [WIDTH-1:0]    w_shifted;
    logic                w_head;

    // Serialisation order only affects which end leaves first and the
    // shift direction; everything else is shared.
`ifdef SEQ_GEN_LSB_FIRST_EN
    assign w_head    = r_shreg[0];
    assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
`else
    assign w_head    = r_shreg[WIDTH-1];
    assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_S_IDLE;
            r_shreg       <= '0;
            r_pat         <= '0;
            r_frames_left <= '0;
            r_gap         <= '0;
            r_gapcnt      <= '0;
            r_bitcnt      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_shreg       <= w_shreg_nxt;
            r_pat         <= w_pat_nxt;
            r_frames_left <= w_frames_left_nxt;
            r_gap         <= w_gap_nxt;
            r_gapcnt      <= w_gapcnt_nxt;
            r_bitcnt      <= w_bitcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_shreg_nxt       = r_shreg;
        w_pat_nxt         = r_pat;
        w_frames_left_nxt = r_frames_left;
        w_gap_nxt         = r_gap;
        w_gapcnt_nxt      = r_gapcnt;
        w_bitcnt_nxt      = r_bitcnt;

        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_shreg_nxt       = pattern;
                    w_pat_nxt         = pattern;
                    w_frames_left_nxt = repeat_cnt;
                    w_gap_nxt         = gap;
                    w_bitcnt_nxt      = '0;
                    w_state_nxt       = c_S_SHIFT;
                end
            end

            c_S_SHIFT: begin
                w_shreg_nxt  = w_shifted;
                w_bitcnt_nxt = r_bitcnt + c_BCW'(1);
                if (r_bitcnt == c_LAST) begin
                    if (r_frames_left == '0) begin
                        w_state_nxt = c_S_DONE;
                    end else if (r_gap == '0) begin
                        // Back-to-back frame: reload without a dead cycle.
                        w_shreg_nxt       = r_pat;
                        w_frames_left_nxt = r_frames_left - REPEAT_W'(1);
                        w_bitcnt_nxt      = '0;
                    end else begin
                        w_gapcnt_nxt = r_gap;
                        w_state_nxt  = c_S_GAP;
                    end
                end
            end

            c_S_GAP: begin
                w_gapcnt_nxt = r_gapcnt - GAP_W'(1);
                // Leaving on gapcnt==1 makes the gap exactly r_gap cycles.
                if (r_gapcnt == GAP_W'(1)) begin
                    w_shreg_nxt       = r_pat;
                    w_frames_left_nxt = r_frames_left - REPEAT_W'(1);
                    w_bitcnt_nxt      = '0;
                    w_state_nxt       = c_S_SHIFT;
                end
            end

            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // Moore outputs: decoded from registers only, so reset clears them
    // without waiting for an edge.
    always_comb begin
        x     = 1'b0;
        valid = 1'b0;
        frame = 1'b0;
        busy  = (r_state != c_S_IDLE);
        done  = (r_state == c_S_DONE);
        if (r_state == c_S_SHIFT) begin
            x     = w_head;
            valid = 1'b1;
            frame = (r_bitcnt == '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_pattern_generator
//  Description : Self-checking bench for seq_pattern_generator. Expected
//                per-cycle output tuples {x,valid,frame,busy,done} are built
//                from the burst description and compared cycle by cycle.
//  Options     : honours SEQ_GEN_LSB_FIRST_EN for the expected bit order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_generator;

    localparam int WIDTH    = 4;
    localparam int REPEAT_W = 4;
    localparam int GAP_W    = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [WIDTH-1:0]    pattern;
    logic [REPEAT_W-1:0] repeat_cnt;
    logic [GAP_W-1:0]    gap;
    logic                x, valid, frame, busy, done;

    int vectors    = 0;
    int miscompares = 0;

    seq_pattern_generator #(
        .WIDTH    (WIDTH),
        .REPEAT_W (REPEAT_W),
        .GAP_W    (GAP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
        .gap        (gap),
        .x          (x),
        .valid      (valid),
        .frame      (frame),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {x, valid, frame, busy, done};
    endfunction

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed {x,valid,frame,busy,done}=%b expected %b", tag, obs, exp);
        end
    endtask

    // Bit b (0 = first transmitted) of a pattern.
    function automatic logic tx_bit(input logic [WIDTH-1:0] p, input int b);
`ifdef SEQ_GEN_LSB_FIRST_EN
        return p[b];
`else
        return p[WIDTH-1-b];
`endif
    endfunction

    // Expected cycle stream for a whole burst, followed by one idle cycle.
    function automatic void build(input logic [WIDTH-1:0] p, input int rep, input int gp,
                                  ref logic [4:0] q[$]);
        q.delete();
        for (int f = 0; f <= rep; f++) begin
            for (int b = 0; b < WIDTH; b++)
                q.push_back({tx_bit(p, b), 1'b1, (b == 0), 1'b1, 1'b0});
            if (f < rep)
                for (int g = 0; g < gp; g++)
                    q.push_back(5'b00010);
        end
        q.push_back(5'b00011);
        q.push_back(5'b00000);
    endfunction

    // Called at a negedge with the DUT idle. Optionally disturbs the
    // inputs and pulses start again on the second bit.
    task automatic run_burst(input string tag, input logic [WIDTH-1:0] p, input int rep,
                             input int gp, input bit disturb);
        logic [4:0] q[$];
        build(p, rep, gp, q);
        pattern    = p;
        repeat_cnt = REPEAT_W'(rep);
        gap        = GAP_W'(gp);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (disturb) begin
            pattern    = WIDTH'($urandom);
            repeat_cnt = REPEAT_W'($urandom);
            gap        = GAP_W'($urandom);
        end
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            check($sformatf("%s cyc%0d", tag, i + 1), outs(), q[i]);
            if (disturb && i == 1) start = 1'b1;
            if (disturb && i == 2) start = 1'b0;
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        pattern    = '0;
        repeat_cnt = '0;
        gap        = '0;
        #1;
        check("reset_async", outs(), 5'b00000);
        repeat (2) @(negedge clk);
        check("reset_held", outs(), 5'b00000);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", outs(), 5'b00000);

        run_burst("s1_1011", 4'b1011, 0, 0, 1'b0);
        run_burst("s2_1001_r1_g2", 4'b1001, 1, 2, 1'b0);
        run_burst("s3_1010_r2_g0", 4'b1010, 2, 0, 1'b0);
        run_burst("s4_ignore_start", 4'b1011, 0, 0, 1'b1);

        // Async reset during the 3rd bit of a burst.
        begin
            logic [4:0] q[$];
            build(4'b0110, 3, 1, q);
            pattern    = 4'b0110;
            repeat_cnt = 4'd3;
            gap        = 4'd1;
            start      = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check($sformatf("s5_pre cyc%0d", i + 1), outs(), q[i]);
            end
            #2;
            rst = 1'b1;
            #1;
            check("s5_async_clear", outs(), 5'b00000);
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check($sformatf("s5_no_done %0d", i), outs(), 5'b00000);
            end
        end
        run_burst("s5_1100", 4'b1100, 0, 0, 1'b0);

        // Maximum-size values.
        run_burst("max_gap", 4'b1101, 1, 15, 1'b0);
        run_burst("max_repeat", 4'b0011, 15, 0, 1'b0);

        // Randomized bursts.
        for (int n = 0; n < 25; n++) begin
            run_burst($sformatf("rnd%0d", n), WIDTH'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                      1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
